// File: rtl/fir_filter_mac_if.sv
// rtl/fir_filter_mac_if.sv - sample, coefficient and result signals of the FIR MAC core
interface fir_filter_mac_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 39
);
  logic              WR;
  logic [DATA_W-1:0] IDATA;
  logic              BYPASS;
  logic              COEF_WE;
  logic [ADDR_W-1:0] COEF_ADDR;
  logic [COEF_W-1:0] COEF_DATA;
  logic              CLR_OVR;
  logic [OUT_W-1:0]  ODATA;
  logic              OVALID;
  logic              BUSY;
  logic              OVERRUN;

  modport master (
    output WR, IDATA, BYPASS, COEF_WE, COEF_ADDR, COEF_DATA, CLR_OVR,
    input  ODATA, OVALID, BUSY, OVERRUN
  );

  modport slave (
    input  WR, IDATA, BYPASS, COEF_WE, COEF_ADDR, COEF_DATA, CLR_OVR,
    output ODATA, OVALID, BUSY, OVERRUN
  );
endinterface

// File: rtl/fir_filter_mac.sv
// rtl/fir_filter_mac.sv - signed FIR filter with loadable coefficients and one time-shared MAC
module fir_filter_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 39
) (
  input logic              CLK,
  input logic              RESET,
  fir_filter_mac_if.slave  bus
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

  if (TAPS < 2) begin : g_bad_taps
    $error("fir_filter_mac: TAPS must be at least 2");
  end
  if (ADDR_W < $clog2(TAPS)) begin : g_bad_addr
    $error("fir_filter_mac: ADDR_W too narrow for TAPS");
  end
  if (OUT_W < DATA_W + COEF_W + $clog2(TAPS)) begin : g_bad_out
    $error("fir_filter_mac: OUT_W too narrow, accumulator could overflow");
  end

  logic [1:0]               state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic signed [OUT_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  odata_q, odata_d;
  logic                     ovalid_q, ovalid_d;
  logic                     overrun_q, overrun_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [COEF_W-1:0] c_d [TAPS];
  logic signed [PROD_W-1:0] prod;
  logic                     busy;

  assign busy = (state_q == ST_MAC);
  assign prod = PROD_W'(x_q[idx_q]) * PROD_W'(c_q[idx_q]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    odata_d   = odata_q;
    ovalid_d  = 1'b0;
    overrun_d = overrun_q;
    x_d       = x_q;
    c_d       = c_q;

    // A dropped event in the same cycle as CLR_OVR keeps the flag set.
    if (busy && (bus.WR || bus.COEF_WE)) begin
      overrun_d = 1'b1;
    end else if (bus.CLR_OVR) begin
      overrun_d = 1'b0;
    end

    if (!busy && bus.COEF_WE && (int'(bus.COEF_ADDR) < TAPS)) begin
      c_d[bus.COEF_ADDR] = $signed(bus.COEF_DATA);
    end

    case (state_q)
      ST_MAC: begin
        acc_d = acc_q + OUT_W'(prod);
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d  = ST_DONE;
          odata_d  = acc_d;
          ovalid_d = 1'b1;
        end
      end
      default: begin
        // DONE behaves like IDLE so back-to-back samples are accepted.
        state_d = ST_IDLE;
        if (bus.WR) begin
          for (int k = TAPS - 1; k > 0; k--) begin
            x_d[k] = x_q[k-1];
          end
          x_d[0] = $signed(bus.IDATA);
          if (bus.BYPASS) begin
            odata_d  = OUT_W'($signed(bus.IDATA));
            ovalid_d = 1'b1;
          end else begin
            acc_d   = '0;
            idx_d   = '0;
            state_d = ST_MAC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      odata_q   <= odata_d;
      ovalid_q  <= ovalid_d;
      overrun_q <= overrun_d;
      x_q       <= x_d;
      c_q       <= c_d;
    end
  end

  assign bus.ODATA   = odata_q;
  assign bus.OVALID  = ovalid_q;
  assign bus.BUSY    = busy;
  assign bus.OVERRUN = overrun_q;
endmodule

// File: tb/tb_fir_filter_mac.sv
// tb/tb_fir_filter_mac.sv - randomized scoreboard bench for fir_filter_mac against a tap-sum model
module tb_fir_filter_mac;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 4;
  localparam int ADDR_W = 2;
  localparam int OUT_W  = 39;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  fir_filter_mac_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

  fir_filter_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ADDR_W(ADDR_W), .OUT_W(OUT_W)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    logic [OUT_W-1:0] val;
    int               due;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  longint m_hist[TAPS];
  longint m_coef[TAPS];
  int     m_busy_left = 0;
  bit     m_ovr = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every OVALID must match the oldest expected result and its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.OVALID === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_ovalid", 64'(bus.ODATA), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("ovalid_cycle", 64'(cyc), 64'(e.due));
          check("odata", 64'(bus.ODATA), 64'(e.val));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("missing_ovalid", 64'(bus.OVALID), 64'd1);
      end
    end
  end

  task automatic drive(input bit wr, input logic [15:0] d, input bit byp,
                       input bit cwe, input logic [1:0] ca, input logic [15:0] cd, input bit clr);
    bus.WR = wr;  bus.IDATA = d;  bus.BYPASS = byp;
    bus.COEF_WE = cwe;  bus.COEF_ADDR = ca;  bus.COEF_DATA = cd;  bus.CLR_OVR = clr;
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_hist[k] = 0;
      m_coef[k] = 0;
    end
    sb.delete();
    m_busy_left = 0;
    m_ovr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_odata"},   64'(bus.ODATA),   64'd0);
    check({tag, "_ovalid"},  64'(bus.OVALID),  64'd0);
    check({tag, "_busy"},    64'(bus.BUSY),    64'd0);
    check({tag, "_overrun"}, 64'(bus.OVERRUN), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_zero("rst_async");
    @(negedge CLK);
    check_zero("rst_hold");
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // One input cycle: check BUSY/OVERRUN against the model, then apply inputs and advance the model.
  task automatic step(input bit wr, input logic [15:0] d, input bit byp,
                      input bit cwe, input logic [1:0] ca, input logic [15:0] cd, input bit clr);
    bit     busy;
    longint y;
    exp_t   e;
    @(negedge CLK);
    busy = (m_busy_left > 0);
    check("busy", 64'(bus.BUSY), 64'(busy));
    check("overrun", 64'(bus.OVERRUN), 64'(m_ovr));
    drive(wr, d, byp, cwe, ca, cd, clr);
    if (busy && (wr || cwe)) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (busy) begin
      m_busy_left--;
    end else begin
      if (cwe && int'(ca) < TAPS) m_coef[ca] = longint'($signed(cd));
      if (wr) begin
        for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = longint'($signed(d));
        if (byp) begin
          y = m_hist[0];
          e.due = cyc + 1;
        end else begin
          y = 0;
          for (int k = 0; k < TAPS; k++) y += m_hist[k] * m_coef[k];
          e.due = cyc + TAPS + 1;
          m_busy_left = TAPS;
        end
        e.val = y[OUT_W-1:0];
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [15:0] d, input bit byp);
    step(1, d, byp, 0, 0, 0, 0);
  endtask

  task automatic wc(input logic [1:0] a, input logic [15:0] v);
    step(0, 0, 0, 1, a, v, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    do_reset();

    // Impulse response
    wc(0, 16'd1); wc(1, 16'd2); wc(2, 16'd3); wc(3, 16'd4);
    wr(16'd1, 0); idle(5);
    repeat (3) begin wr(16'd0, 0); idle(5); end
    idle(1);

    // Signed extremes
    for (int a = 0; a < TAPS; a++) wc(2'(a), 16'h8000);
    repeat (4) begin wr(16'h8000, 0); idle(5); end
    do_reset();
    wc(0, 16'hFFFF); wr(16'h8000, 0); idle(6);

    // Overrun: dropped sample, dropped coefficient write, then clear
    do_reset();
    wc(0, 16'd1);
    wr(16'd5, 0); idle(1); wr(16'd7, 0); wc(0, 16'h0055); idle(3);
    step(0, 0, 0, 0, 0, 0, 1); idle(2);
    wr(16'd2, 0); idle(6);

    // Bypass keeps history
    wr(16'h8000, 1); idle(1);
    wc(0, 16'd0); wc(1, 16'd1);
    wr(16'd0, 0); idle(6);

    // Reset in the middle of a MAC sequence
    wr(16'd3, 0); idle(2);
    do_reset();
    wc(0, 16'd1); wr(16'd9, 0); idle(6);

    // Randomized traffic
    repeat (500) begin
      step(($urandom_range(0, 2) == 0), 16'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), 2'($urandom), 16'($urandom), ($urandom_range(0, 9) == 0));
    end
    idle(TAPS + 4);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
